// File: rtl/img_conv_pkg.sv
// Shared types and constants for the image convolution controller.
//   opcode_t     : command opcodes on the en/op/din/dout interface
//   ctrl_state_t : sequencer states (idle plus one state per job type)
//   STATUS_*     : bit positions inside the status byte
//   pack_status  : assembles the status byte from the individual flags
package img_conv_pkg;

    typedef enum logic [3:0] {
        OP_NOP        = 4'd0,
        OP_SET_NROWS  = 4'd1,
        OP_SET_NCOLS  = 4'd2,
        OP_SET_SIGMA  = 4'd3,
        OP_GET_NROWS  = 4'd4,
        OP_GET_NCOLS  = 4'd5,
        OP_GET_SIGMA  = 4'd6,
        OP_IMG_RX     = 4'd7,
        OP_IMG_TX     = 4'd8,
        OP_CONV       = 4'd9,
        OP_GET_STATUS = 4'd10,
        OP_CLR_ERR    = 4'd11
    } opcode_t;

    typedef enum logic [1:0] {
        StIdle,
        StRx,
        StTx,
        StConv
    } ctrl_state_t;

    localparam int unsigned STATUS_ERR_CFG   = 0;
    localparam int unsigned STATUS_ERR_OP    = 1;
    localparam int unsigned STATUS_ERR_TMO   = 2;
    localparam int unsigned STATUS_IMG_VALID = 3;

    function automatic logic [7:0] pack_status(input logic err_cfg, input logic err_op,
                                               input logic err_tmo, input logic img_valid);
        logic [7:0] s;
        s                   = '0;
        s[STATUS_ERR_CFG]   = err_cfg;
        s[STATUS_ERR_OP]    = err_op;
        s[STATUS_ERR_TMO]   = err_tmo;
        s[STATUS_IMG_VALID] = img_valid;
        return s;
    endfunction

endpackage

// File: rtl/img_conv_watchdog.sv
// Job watchdog: counts busy cycles and flags the cycle in which the job has
// been busy for TIMEOUT_CYC cycles. TIMEOUT_CYC = 0 disables it.
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   clr_i        : hold the counter at zero (asserted while idle)
//   en_i         : count this cycle (asserted while a job runs)
//   expire_o     : high during the last allowed busy cycle
module img_conv_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 0,
    parameter int unsigned TMO_W       = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [TMO_W-1:0] LastCnt = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds the number of busy cycles already completed, so the
    // TIMEOUT_CYC-th busy cycle is the one where cnt_q == TIMEOUT_CYC-1.
    assign expire_o = (TIMEOUT_CYC != 0) && en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/img_conv_ctrl.sv
// Command sequencer for the image convolution block. Decodes opcodes, holds
// the nrows/ncols/sigma configuration and sticky status, and launches one
// RX/TX/CONV job at a time with start/done handshakes and an optional watchdog.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   en_i, op_i, din_i       : command strobe, opcode, write data
//   dout_o                  : registered read data of the last GET
//   busy_o                  : a job is in progress
//   nrows_o/ncols_o/sigma_o : configuration to the datapath
//   *_start_o / *_done_i    : per-job launch pulse and completion pulse
//   err_o                   : OR of the sticky error bits
module img_conv_ctrl
    import img_conv_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 0,
    parameter int unsigned TMO_W       = 20
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  opcode_t           op_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] nrows_o,
    output logic [DATA_W-1:0] ncols_o,
    output logic [DATA_W-1:0] sigma_o,
    output logic              rx_start_o,
    input  logic              rx_done_i,
    output logic              tx_start_o,
    input  logic              tx_done_i,
    output logic              conv_start_o,
    input  logic              conv_done_i,
    output logic              err_o
);

    ctrl_state_t       state_q;
    logic              busy_q;
    logic [DATA_W-1:0] nrows_q, ncols_q, sigma_q, dout_q;
    logic              err_cfg_q, err_op_q, err_tmo_q, img_valid_q;
    logic              rx_start_q, tx_start_q, conv_start_q;

    logic       job_done;
    logic       wdt_expire;
    logic [7:0] status;

    assign status = pack_status(err_cfg_q, err_op_q, err_tmo_q, img_valid_q);

    // A done seen while the start pulse is still high belongs to the launch
    // cycle and is ignored.
    always_comb begin
        job_done = 1'b0;
        case (state_q)
            StRx:    job_done = rx_done_i;
            StTx:    job_done = tx_done_i;
            StConv:  job_done = conv_done_i;
            default: job_done = 1'b0;
        endcase
        if (rx_start_q || tx_start_q || conv_start_q) begin
            job_done = 1'b0;
        end
    end

    img_conv_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TMO_W      (TMO_W)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (state_q == StIdle),
        .en_i    (busy_q),
        .expire_o(wdt_expire)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            nrows_q      <= '0;
            ncols_q      <= '0;
            sigma_q      <= '0;
            dout_q       <= '0;
            err_cfg_q    <= 1'b0;
            err_op_q     <= 1'b0;
            err_tmo_q    <= 1'b0;
            img_valid_q  <= 1'b0;
            rx_start_q   <= 1'b0;
            tx_start_q   <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            rx_start_q   <= 1'b0;
            tx_start_q   <= 1'b0;
            conv_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (en_i) begin
                        case (op_i)
                            OP_NOP: ;
                            OP_SET_NROWS: begin
                                nrows_q     <= din_i;
                                img_valid_q <= 1'b0;
                            end
                            OP_SET_NCOLS: begin
                                ncols_q     <= din_i;
                                img_valid_q <= 1'b0;
                            end
                            OP_SET_SIGMA:  sigma_q <= din_i;
                            OP_GET_NROWS:  dout_q  <= nrows_q;
                            OP_GET_NCOLS:  dout_q  <= ncols_q;
                            OP_GET_SIGMA:  dout_q  <= sigma_q;
                            OP_GET_STATUS: dout_q  <= DATA_W'(status);
                            OP_IMG_RX: begin
                                if (nrows_q != '0 && ncols_q != '0) begin
                                    state_q    <= StRx;
                                    busy_q     <= 1'b1;
                                    rx_start_q <= 1'b1;
                                end else begin
                                    err_cfg_q <= 1'b1;
                                end
                            end
                            OP_IMG_TX: begin
                                if (img_valid_q) begin
                                    state_q    <= StTx;
                                    busy_q     <= 1'b1;
                                    tx_start_q <= 1'b1;
                                end else begin
                                    err_cfg_q <= 1'b1;
                                end
                            end
                            OP_CONV: begin
                                if (img_valid_q && sigma_q != '0) begin
                                    state_q      <= StConv;
                                    busy_q       <= 1'b1;
                                    conv_start_q <= 1'b1;
                                end else begin
                                    err_cfg_q <= 1'b1;
                                end
                            end
                            OP_CLR_ERR: begin
                                err_cfg_q <= 1'b0;
                                err_op_q  <= 1'b0;
                                err_tmo_q <= 1'b0;
                            end
                            default: err_op_q <= 1'b1;
                        endcase
                    end
                end
                default: begin
                    // Done has priority over a coinciding watchdog expiry.
                    if (job_done) begin
                        if (state_q == StRx) begin
                            img_valid_q <= 1'b1;
                        end
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (wdt_expire) begin
                        if (state_q == StRx) begin
                            img_valid_q <= 1'b0;
                        end
                        err_tmo_q <= 1'b1;
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign dout_o       = dout_q;
    assign busy_o       = busy_q;
    assign nrows_o      = nrows_q;
    assign ncols_o      = ncols_q;
    assign sigma_o      = sigma_q;
    assign rx_start_o   = rx_start_q;
    assign tx_start_o   = tx_start_q;
    assign conv_start_o = conv_start_q;
    assign err_o        = err_cfg_q | err_op_q | err_tmo_q;

endmodule

// File: doc/img_conv_ctrl.md
Name: img_conv_ctrl

Overview:
Command sequencer between the external en/op/din/dout/busy interface of img_conv_top and the datapath sub-controllers (io_rx_controller, io_tx_controller, convolution engine). It decodes opcodes, holds the nrows/ncols/sigma configuration and status registers, and launches one job at a time with start/done handshakes. It drives busy, checks preconditions and runs an optional watchdog.

Parameters:
DATA_W, 8, width of din/dout and config registers
TIMEOUT_CYC, 0, max cycles a job may stay busy before abort; 0 disables the watchdog
TMO_W, 20, watchdog counter width; must satisfy TIMEOUT_CYC < 2**TMO_W

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
en  in  1  command strobe, sampled at posedge
op  in  opcode_t  command opcode (img_conv_pkg)
din  in  DATA_W  write data for SET ops
dout  out  DATA_W  registered read data for GET ops
busy  out  1  job in progress
nrows  out  DATA_W  configured row count to datapath
ncols  out  DATA_W  configured column count to datapath
sigma  out  DATA_W  configured sigma to datapath
rx_start  out  1  one-cycle launch pulse to RX controller
rx_done  in  1  RX complete pulse
tx_start  out  1  one-cycle launch pulse to TX controller
tx_done  in  1  TX complete pulse
conv_start  out  1  one-cycle launch pulse to conv engine
conv_done  in  1  conv complete pulse
err  out  1  OR of sticky error bits

Behaviour:
- Reset: every output is 0; nrows/ncols/sigma/status are 0; state is IDLE.
- States: IDLE, RX, TX, CONV (ctrl_state_t). busy = (state != IDLE), registered.
- IDLE, en=1 at posedge, by op:
  - NOP: no effect.
  - SET_NROWS/NCOLS/SIGMA: load din at that edge. SET_NROWS/NCOLS also clear img_valid.
  - GET_NROWS/NCOLS/SIGMA/STATUS: dout loaded at that edge and holds until the next GET.
  - IMG_RX: requires nrows!=0 and ncols!=0.
  - IMG_TX: requires img_valid.
  - CONV: requires img_valid and sigma!=0.
  - Launch: at the same edge, the matching *_start goes 1 for exactly one cycle and the state enters the job state. busy is visible one cycle after en is sampled.
  - Precondition fails: set err_cfg, stay IDLE, no start pulse.
  - CLR_ERR: clear all error bits.
  - Unrecognised encoding: set err_op.
- Job states:
  - Only the matching *_done is honoured. On a done sampled high, the next state is IDLE and busy falls at that edge.
  - RX done sets img_valid. CONV done keeps img_valid.
  - en/op/din are ignored while busy. Config registers and dout hold.
  - done pulses in IDLE, non-matching done pulses, and a done asserted in the launch cycle itself are ignored; done is sampled from the cycle after start.
- Watchdog (TIMEOUT_CYC>0):
  - Counter is cleared on launch and increments each busy cycle.
  - When count reaches TIMEOUT_CYC without done: set err_tmo, go IDLE. RX timeout also clears img_valid.
  - If done and timeout coincide, done wins and no error is recorded.
- Status byte: bit0 err_cfg, bit1 err_op, bit2 err_tmo, bit3 img_valid, bits7:4 = 0. err = |status[2:0].
- Reset mid-job: immediate return to reset values; no done is awaited.

Decomposition:
- img_conv_pkg:
  - existing opcode_t gains OP_GET_STATUS and OP_CLR_ERR
  - ctrl_state_t
  - STATUS_* bit-index constants
- One sub-module: img_conv_watchdog (counter, clear/enable inputs, expire pulse).

Test Plan:
- Reset, then SET_NROWS din=16, then GET_NROWS -> dout=16 one edge later. Repeat for NCOLS=16 and SIGMA=5.
- IMG_RX with nrows=16, ncols=16 -> rx_start high exactly 1 cycle; busy=1 until rx_done (model after 256 cycles); busy falls on the done edge; GET_STATUS -> 0x08.
- IMG_TX with img_valid=0 after reset, with nrows=0 -> no tx_start, busy stays 0, err=1, GET_STATUS=0x01; CLR_ERR -> err=0.
- During a CONV job: SET_SIGMA din=9, stray rx_done, and en pulses -> sigma stays 5, busy holds, only conv_done ends the job.
- TIMEOUT_CYC=10, IMG_TX with no tx_done -> busy falls after 10 busy cycles, status=0x0C. Repeat with tx_done on cycle 10 -> status=0x08.
- Assert rstn=0 mid-RX -> busy, start pulses, dout and config are 0 immediately; after release, GET_NROWS returns 0.
